// File: rtl/slant_rx_pkg.sv
// slant_rx_pkg: SLANT link constants and receiver state encoding shared with the transmitter
package slant_rx_pkg;
  localparam logic [23:0] FRAME1_PAT = 24'haab155;
  localparam logic [23:0] FRAME0_PAT = 24'haa8d55;
  localparam logic [15:0] HSYNC_PAT  = 16'ha355;
  localparam logic [5:0]  MARKER_SYM = 6'h3f;
  typedef enum logic [1:0] {HUNT, DATA, GAP} state_e;
endpackage

// File: rtl/slant_rx_if.sv
// slant_rx_if: four-lane SLANT symbol bus with a one-cycle strobe
interface slant_rx_if;
  logic       RxValid;
  logic [5:0] Rx0Data, Rx1Data, Rx2Data, Rx3Data;
  modport master(output RxValid, Rx0Data, Rx1Data, Rx2Data, Rx3Data);
  modport slave(input RxValid, Rx0Data, Rx1Data, Rx2Data, Rx3Data);
endinterface

// File: rtl/slant_marker_det.sv
// slant_marker_det: marker-bit shift register with frame and line-sync comparators
module slant_marker_det
  import slant_rx_pkg::*;
#(
  parameter logic [23:0] FRAME1 = FRAME1_PAT,
  parameter logic [23:0] FRAME0 = FRAME0_PAT,
  parameter logic [15:0] HSYNC  = HSYNC_PAT
) (
  input  logic Cclk,
  input  logic rstn,
  input  logic shift_en,
  input  logic mk_bit,
  output logic frame_hit,
  output logic odd_hit,
  output logic hsync_hit
);
  logic [23:0] mk_sr_q, mk_sr_d;
  // matches look at the value being loaded so they act on the completing symbol
  always_comb mk_sr_d = shift_en ? {mk_sr_q[22:0], mk_bit} : mk_sr_q;
  assign odd_hit   = shift_en && mk_sr_d == FRAME1;
  assign frame_hit = odd_hit || (shift_en && mk_sr_d == FRAME0);
  assign hsync_hit = shift_en && mk_sr_d[15:0] == HSYNC;
  always_ff @(posedge Cclk or negedge rstn)
    if (!rstn) mk_sr_q <= '0;
    else       mk_sr_q <= mk_sr_d;
endmodule

// File: rtl/slant_rx.sv
// slant_rx: SLANT four-lane receiver, framing FSM and Y/C pixel group assembly
module slant_rx
  import slant_rx_pkg::*;
#(
  parameter logic [23:0] FRAME1          = FRAME1_PAT,
  parameter logic [23:0] FRAME0          = FRAME0_PAT,
  parameter logic [15:0] HSYNC           = HSYNC_PAT,
  parameter int          PAIRS_PER_LINE  = 40,
  parameter int          LINES_PER_FRAME = 960,
  parameter int          GAP_TIMEOUT     = 32
) (
  input  logic        Cclk,
  input  logic        rstn,
  slant_rx_if.slave   rx,
  input  logic        err_clr,
  output logic        m_valid,
  output logic [39:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_odd,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);
  localparam int PW = $clog2(PAIRS_PER_LINE + 1);
  localparam int LW = $clog2(LINES_PER_FRAME + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(PAIRS_PER_LINE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);
  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            phase_q, phase_d, sof_pend_q, sof_pend_d, odd_q, odd_d;
  logic [19:0]     y_q, y_d;
  logic [39:0]     data_q, data_d;
  logic            valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, done_q, done_d;
  logic [7:0]      err_q, err_d;
  logic [3:0][5:0] lane;
  logic [19:0]     val;
  logic [3:0]      hi;
  logic            agree, mk_bit, frame_hit, odd_hit, hsync_hit, err_inc;
  assign lane   = {rx.Rx3Data, rx.Rx2Data, rx.Rx1Data, rx.Rx0Data};
  assign val    = {lane[3][4:0], lane[2][4:0], lane[1][4:0], lane[0][4:0]};
  assign hi     = {lane[3][5], lane[2][5], lane[1][5], lane[0][5]};
  assign agree  = lane[3] == lane[0] && lane[2] == lane[0] && lane[1] == lane[0];
  assign mk_bit = agree && lane[0] == MARKER_SYM;
  slant_marker_det #(.FRAME1(FRAME1), .FRAME0(FRAME0), .HSYNC(HSYNC)) u_det (
    .Cclk(Cclk), .rstn(rstn), .shift_en(rx.RxValid), .mk_bit(mk_bit),
    .frame_hit(frame_hit), .odd_hit(odd_hit), .hsync_hit(hsync_hit)
  );
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    pair_d     = pair_q;
    gap_d      = gap_q;
    phase_d    = phase_q;
    sof_pend_d = sof_pend_q;
    odd_d      = odd_q;
    y_d        = y_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    done_d     = 1'b0;
    err_inc    = 1'b0;
    if (rx.RxValid) begin
      if (frame_hit) begin
        state_d    = DATA;
        line_d     = '0;
        pair_d     = '0;
        phase_d    = 1'b0;
        odd_d      = odd_hit;
        sof_pend_d = 1'b1;
      end else if (state_q == DATA) begin
        err_inc = |hi;
        phase_d = ~phase_q;
        if (!phase_q) y_d = val;
        else begin
          valid_d    = 1'b1;
          sof_d      = sof_pend_q;
          sof_pend_d = 1'b0;
          data_d     = {val[19:15], y_q[19:15], val[14:10], y_q[14:10],
                        val[9:5], y_q[9:5], val[4:0], y_q[4:0]};
          eol_d      = pair_q == PAIR_LAST;
          pair_d     = eol_d ? '0 : pair_q + 1'b1;
          if (eol_d) begin
            done_d  = line_q == LINE_LAST;
            state_d = done_d ? HUNT : GAP;
            gap_d   = '0;
          end
        end
      end else begin
        err_inc = !agree;
        if (state_q == GAP) begin
          if (hsync_hit) begin
            state_d = DATA;
            line_d  = line_q + 1'b1;
            pair_d  = '0;
            phase_d = 1'b0;
          end else if (gap_q == GAP_LAST) begin
            state_d = HUNT;
            err_inc = 1'b1;
          end else gap_d = gap_q + 1'b1;
        end
      end
    end
  end
  always_comb err_d = err_clr ? 8'h00 : (err_inc && err_q != 8'hff) ? err_q + 8'h01 : err_q;
  always_ff @(posedge Cclk or negedge rstn)
    if (!rstn) begin
      state_q    <= HUNT;
      line_q     <= '0;
      pair_q     <= '0;
      gap_q      <= '0;
      phase_q    <= 1'b0;
      sof_pend_q <= 1'b0;
      odd_q      <= 1'b0;
      y_q        <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      pair_q     <= pair_d;
      gap_q      <= gap_d;
      phase_q    <= phase_d;
      sof_pend_q <= sof_pend_d;
      odd_q      <= odd_d;
      y_q        <= y_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_sof      = sof_q;
  assign m_eol      = eol_q;
  assign frame_odd  = odd_q;
  assign frame_done = done_q;
  assign err_cnt    = err_q;
endmodule
